// File: rtl/instr_encoder.sv
// instr_encoder: turns mnemonic requests into MIPS instruction words with sequential byte addresses.
// Define ENCODER_PSEUDO_LI_EN to expand the li pseudo-instruction into one or two words (adds EMIT2).
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
);

`ifdef ENCODER_PSEUDO_LI_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, EMIT2 = 2'd2} state_t;
    typedef struct packed {logic ok; logic two; logic [31:0] w0; logic [31:0] w1;} enc_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1} state_t;
    typedef struct packed {logic ok; logic [31:0] w0;} enc_t;
`endif

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic enc_t encode(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                    input logic [4:0] rd, input logic [31:0] imm);
        enc_t e;
        e    = '0;
        e.ok = 1'b1;
        case (op)
            5'd0:    e.w0 = rtype(rs, rt, rd, 6'b100001);
            5'd1:    e.w0 = rtype(rs, rt, rd, 6'b100011);
            5'd2:    e.w0 = rtype(rs, rt, rd, 6'b100100);
            5'd3:    e.w0 = rtype(rs, rt, rd, 6'b100101);
            5'd4:    e.w0 = rtype(rs, rt, rd, 6'b101011);
            5'd5:    e.w0 = rtype(rs, rt, rd, 6'b011011);
            5'd6:    e.w0 = rtype(rs, rt, rd, 6'b010000);
            5'd7:    e.w0 = rtype(rs, rt, rd, 6'b010010);
            5'd8:    e.w0 = rtype(rs, rt, rd, 6'b011001);
            5'd9:    e.w0 = {6'b000000, rs, 15'd0, 6'b001000};
            5'd10:   e.w0 = itype(6'b100011, rs, rt, imm[15:0]);
            5'd11:   e.w0 = itype(6'b101011, rs, rt, imm[15:0]);
            5'd12:   e.w0 = itype(6'b000100, rs, rt, imm[15:0]);
            5'd13:   e.w0 = itype(6'b001001, rs, rt, imm[15:0]);
            5'd14:   e.w0 = {6'b000010, imm[25:0]};
            5'd15:   e.w0 = {6'b000011, imm[25:0]};
            5'd16:   e.w0 = itype(6'b001101, rs, rt, imm[15:0]);
            5'd17:   e.w0 = itype(6'b001111, 5'd0, rt, imm[15:0]);
            5'd18:   e.w0 = itype(6'b000001, rs, 5'd0, imm[15:0]);
`ifdef ENCODER_PSEUDO_LI_EN
            5'd19: begin
                if (imm[31:16] == 16'd0) begin
                    e.w0 = itype(6'b001101, 5'd0, rt, imm[15:0]);
                end else begin
                    e.two = 1'b1;
                    e.w0  = itype(6'b001111, 5'd0, rt, imm[31:16]);
                    e.w1  = itype(6'b001101, rt, rt, imm[15:0]);
                end
            end
`endif
            default: e.ok = 1'b0;
        endcase
        return e;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        out_valid_r, valid_nxt_s;
    logic [31:0] out_instr_r, instr_nxt_s;
    logic [31:0] out_addr_r, addr_nxt_s;
    logic        err_r, err_nxt_s;
    logic        in_fire_s, out_fire_s;
    enc_t        enc_s;
`ifdef ENCODER_PSEUDO_LI_EN
    logic        li_first_r, li_first_nxt_s;
    logic [31:0] pend_r, pend_nxt_s;
`else
    logic        unused_imm_s;
    assign unused_imm_s = ^in_imm[31:26];
`endif

    assign out_valid = out_valid_r;
    assign out_instr = out_instr_r;
    assign out_addr  = out_addr_r;
    assign err       = err_r;

    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_r & out_ready;
    assign enc_s      = encode(in_op, in_rs, in_rt, in_rd, in_imm);

    // Accept when the output slot is free, or is draining this cycle with no ori half queued behind it.
    always_comb begin
`ifdef ENCODER_PSEUDO_LI_EN
        in_ready = (state_r == IDLE) | (out_ready & (state_r == EMIT) & ~li_first_r)
                 | (out_ready & (state_r == EMIT2));
`else
        in_ready = (state_r == IDLE) | (out_ready & (state_r == EMIT));
`endif
    end

    // Next-state and next-output logic; an accept can only coincide with a drain, so it takes priority.
    always_comb begin
        state_nxt_s = state_r;
        valid_nxt_s = out_valid_r;
        instr_nxt_s = out_instr_r;
        err_nxt_s   = 1'b0;
        addr_nxt_s  = out_fire_s ? (out_addr_r + 32'd4) : out_addr_r;
`ifdef ENCODER_PSEUDO_LI_EN
        li_first_nxt_s = li_first_r;
        pend_nxt_s     = pend_r;
`endif
        if (in_fire_s) begin
            if (enc_s.ok) begin
                state_nxt_s = EMIT;
                valid_nxt_s = 1'b1;
                instr_nxt_s = enc_s.w0;
`ifdef ENCODER_PSEUDO_LI_EN
                li_first_nxt_s = enc_s.two;
                pend_nxt_s     = enc_s.w1;
`endif
            end else begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
                err_nxt_s   = 1'b1;
`ifdef ENCODER_PSEUDO_LI_EN
                li_first_nxt_s = 1'b0;
`endif
            end
        end else if (out_fire_s) begin
`ifdef ENCODER_PSEUDO_LI_EN
            if (li_first_r) begin
                state_nxt_s    = EMIT2;
                instr_nxt_s    = pend_r;
                li_first_nxt_s = 1'b0;
            end else begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
            end
`else
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
`endif
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers; reset also drops any queued li second half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_addr_r  <= 32'd0;
            err_r       <= 1'b0;
`ifdef ENCODER_PSEUDO_LI_EN
            li_first_r  <= 1'b0;
            pend_r      <= 32'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= valid_nxt_s;
            out_instr_r <= instr_nxt_s;
            out_addr_r  <= addr_nxt_s;
            err_r       <= err_nxt_s;
`ifdef ENCODER_PSEUDO_LI_EN
            li_first_r  <= li_first_nxt_s;
            pend_r      <= pend_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, hand-written corner sequences and a
// randomized run scored by a word-queue model of the encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = 5'd0, in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr, out_addr;
    logic        err;

    int total = 0;
    int bad = 0;

    instr_encoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: field positions expressed as shifts and table lookups.
    int unsigned funct_tab [9] = '{32'h21, 32'h23, 32'h24, 32'h25, 32'h2B, 32'h1B, 32'h10, 32'h12, 32'h19};
    int unsigned opc_tab [19]  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h23, 32'h2B, 32'h04, 32'h09, 32'h02, 32'h03, 32'h0D, 32'h0F, 32'h01};

    function automatic void model(input int unsigned op, input int unsigned rs, input int unsigned rt,
                                  input int unsigned rd, input int unsigned imm,
                                  output int n, output int unsigned w0, output int unsigned w1);
        int unsigned lo, hi;
        lo = imm & 32'hFFFF;
        hi = imm >> 16;
        n = 1; w0 = 32'd0; w1 = 32'd0;
        if (op <= 32'd8)                      w0 = (rs << 21) + (rt << 16) + (rd << 11) + funct_tab[op];
        else if (op == 32'd9)                 w0 = (rs << 21) + 32'd8;
        else if (op == 32'd14 || op == 32'd15) w0 = (opc_tab[op] << 26) + (imm & 32'h03FFFFFF);
        else if (op == 32'd17)                w0 = (opc_tab[op] << 26) + (rt << 16) + lo;
        else if (op == 32'd18)                w0 = (32'd1 << 26) + (rs << 21) + lo;
        else if (op <= 32'd16)                w0 = (opc_tab[op] << 26) + (rs << 21) + (rt << 16) + lo;
`ifdef ENCODER_PSEUDO_LI_EN
        else if (op == 32'd19) begin
            if (hi == 32'd0) w0 = (32'h0D << 26) + (rt << 16) + lo;
            else begin
                n  = 2;
                w0 = (32'h0F << 26) + (rt << 16) + hi;
                w1 = (32'h0D << 26) + (rt << 21) + (rt << 16) + lo;
            end
        end
`endif
        else n = 0;
    endfunction

    // Scoreboard: pending words in order, next address, and expected err pulse.
    logic [31:0] exp_q [$];
    logic [31:0] exp_addr = 32'd0;
    logic        err_due = 1'b0;

    always @(negedge clk) begin
        int n;
        int unsigned w0, w1;
        if (!reset) begin
            exp_q.delete();
            exp_addr = 32'd0;
            err_due  = 1'b0;
        end else begin
            check("mon_err", 32'(err), 32'(err_due));
            check("mon_out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("mon_in_ready", 32'(in_ready),
                  32'((exp_q.size() == 0) || (out_ready && exp_q.size() == 1)));
            if (out_valid && exp_q.size() != 0) begin
                check("mon_out_instr", out_instr, exp_q[0]);
                check("mon_out_addr", out_addr, exp_addr);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_addr = exp_addr + 32'd4;
            end
            err_due = 1'b0;
            if (in_valid && in_ready) begin
                model(in_op, in_rs, in_rt, in_rd, in_imm, n, w0, w1);
                if (n == 0) err_due = 1'b1;
                if (n >= 1) exp_q.push_back(w0);
                if (n == 2) exp_q.push_back(w1);
            end
        end
    end

    typedef struct {
        logic [4:0]  op, rs, rt, rd;
        logic [31:0] imm;
        int          n;
        logic [31:0] w0, w1;
    } vec_t;
    vec_t vec [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] imm);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (!out_valid) break;
            tick();
        end
        check("idle_timeout", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] base;
        vec[0]  = '{5'd0,  5'd1,  5'd2, 5'd3, 32'd0,        1, 32'h00221821, 32'd0};
        vec[1]  = '{5'd1,  5'd4,  5'd5, 5'd6, 32'd0,        1, 32'h00853023, 32'd0};
        vec[2]  = '{5'd9,  5'd31, 5'd7, 5'd7, 32'd0,        1, 32'h03E00008, 32'd0};
        vec[3]  = '{5'd10, 5'd29, 5'd8, 5'd0, 32'd4,        1, 32'h8FA80004, 32'd0};
        vec[4]  = '{5'd17, 5'd7,  5'd9, 5'd0, 32'h1234,     1, 32'h3C091234, 32'd0};
        vec[5]  = '{5'd18, 5'd3,  5'd5, 5'd0, 32'hFFF8,     1, 32'h0460FFF8, 32'd0};
        vec[6]  = '{5'd14, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFF, 1, 32'h0BFFFFFF, 32'd0};
        vec[7]  = '{5'd12, 5'd1,  5'd2, 5'd0, 32'h0010,     1, 32'h10220010, 32'd0};
        vec[8]  = '{5'd8,  5'd8,  5'd9, 5'd0, 32'd0,        1, 32'h01090019, 32'd0};
        vec[9]  = '{5'd31, 5'd1,  5'd1, 5'd1, 32'd0,        0, 32'd0,        32'd0};
        vec[10] = '{5'd20, 5'd2,  5'd2, 5'd2, 32'd5,        0, 32'd0,        32'd0};
        vec[13] = '{5'd16, 5'd2,  5'd3, 5'd0, 32'hFFFF0F0F, 1, 32'h34430F0F, 32'd0};
`ifdef ENCODER_PSEUDO_LI_EN
        vec[11] = '{5'd19, 5'd0,  5'd9, 5'd0, 32'h12345678, 2, 32'h3C091234, 32'h35295678};
        vec[12] = '{5'd19, 5'd0,  5'd9, 5'd0, 32'h0000ABCD, 1, 32'h3409ABCD, 32'd0};
`else
        vec[11] = '{5'd19, 5'd0,  5'd9, 5'd0, 32'h12345678, 0, 32'd0, 32'd0};
        vec[12] = '{5'd19, 5'd0,  5'd9, 5'd0, 32'h0000ABCD, 0, 32'd0, 32'd0};
`endif

        #2 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // addu at address 0
        drive(5'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        tick();
        in_valid = 1'b0;
        check("addu_instr", out_instr, 32'h00221821);
        check("addu_addr", out_addr, 32'd0);
        tick();

        // lw then jal back-to-back from a fresh reset
        reset = 1'b0; tick(); reset = 1'b1; tick();
        drive(5'd10, 5'd29, 5'd8, 5'd0, 32'd4);
        tick();
        check("b2b_lw_instr", out_instr, 32'h8FA80004);
        check("b2b_lw_addr", out_addr, 32'd0);
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        drive(5'd15, 5'd0, 5'd0, 5'd0, 32'h100);
        tick();
        in_valid = 1'b0;
        check("b2b_jal_valid", 32'(out_valid), 32'd1);
        check("b2b_jal_instr", out_instr, 32'h0C000100);
        check("b2b_jal_addr", out_addr, 32'd4);
        tick();

        // directed vector table
        for (int i = 0; i < 14; i++) begin
            wait_idle();
            base = exp_addr;
            drive(vec[i].op, vec[i].rs, vec[i].rt, vec[i].rd, vec[i].imm);
            tick();
            in_valid = 1'b0;
            if (vec[i].n == 0) begin
                check($sformatf("vec%0d_err", i), 32'(err), 32'd1);
                check($sformatf("vec%0d_no_valid", i), 32'(out_valid), 32'd0);
                tick();
                check($sformatf("vec%0d_err_pulse", i), 32'(err), 32'd0);
                check($sformatf("vec%0d_addr_kept", i), out_addr, base);
            end else begin
                check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
                check($sformatf("vec%0d_w0", i), out_instr, vec[i].w0);
                if (vec[i].n == 2) begin
                    check($sformatf("vec%0d_lui_in_ready", i), 32'(in_ready), 32'd0);
                    tick();
                    check($sformatf("vec%0d_w1", i), out_instr, vec[i].w1);
                    check($sformatf("vec%0d_w1_addr", i), out_addr, base + 32'd4);
                end
            end
        end

        // output stall: word must hold for three cycles, then drain on first ready
        wait_idle();
        base = exp_addr;
        out_ready = 1'b0;
        drive(5'd1, 5'd4, 5'd5, 5'd6, 32'd0);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_instr", out_instr, 32'h00853023);
            check("stall_addr", out_addr, base);
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("stall_released", 32'(out_valid), 32'd0);
        check("stall_addr_next", out_addr, base + 32'd4);

        // reset in the middle of an li expansion drops the ori half
        wait_idle();
        out_ready = 1'b0;
`ifdef ENCODER_PSEUDO_LI_EN
        drive(5'd19, 5'd0, 5'd9, 5'd0, 32'h12345678);
`else
        drive(5'd0, 5'd1, 5'd2, 5'd3, 32'd0);
`endif
        tick();
        in_valid = 1'b0;
        check("gap_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("gap_rst_valid", 32'(out_valid), 32'd0);
        check("gap_rst_addr", out_addr, 32'd0);
        check("gap_rst_instr", out_instr, 32'd0);
        out_ready = 1'b1;
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gap_no_ori", 32'(out_valid), 32'd0);
        end

        // randomized traffic scored by the monitor
        for (int c = 0; c < 600; c++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            in_valid  = ($urandom_range(0, 9) < 6);
            in_op     = (r == 0) ? 5'd19 : ((r == 1) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 18)));
            in_rs     = 5'($urandom);
            in_rt     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_imm    = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF) : $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
